assoc_branch_target_buffer: RTL and testbench

Parametrised set-associative branch target buffer with per-entry saturating direction counters, the next generation of the direct-mapped BTB in the RISC-V pipeline CPU. It predicts next-PC in the IF stage from PCF and is trained from EX-stage branch resolution. Associativity, set count and counter width are parameters. Replacement is LRU, training is hysteresis-based, and a whole-table flush is provided.

---
 rtl/assoc_branch_target_buffer.sv | 132 +++++++++++++
 tb/tb_assoc_branch_target_buffer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/assoc_branch_target_buffer.sv
// Set-associative branch target buffer with LRU replacement and saturating direction counters.
// Lookup is combinational on PCF; training from EX-stage resolution commits at the clock edge.
module assoc_branch_target_buffer #(
  parameter int SET_ADDR_LEN = 3,
  parameter int WAYS         = 2,
  parameter int CNT_BITS     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        HitF,
  output logic        PredTakenF,
  output logic [31:0] PredictPC,
  input  logic        UpdateE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BrNPC,
  input  logic        Flush
);
  localparam int TAG_LEN = 30 - SET_ADDR_LEN;
  localparam int SETS    = 1 << SET_ADDR_LEN;
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [WAY_W-1:0]    AGE_OLD  = WAY_W'(WAYS - 1);

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_BITS'(1);
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_dec(input logic [CNT_BITS-1:0] c);
    return (c == '0) ? c : c - CNT_BITS'(1);
  endfunction

  logic                valid_q [SETS][WAYS];
  logic [TAG_LEN-1:0]  tag_q   [SETS][WAYS];
  logic [31:0]         tgt_q   [SETS][WAYS];
  logic [CNT_BITS-1:0] cnt_q   [SETS][WAYS];
  logic [WAY_W-1:0]    age_q   [SETS][WAYS];

  logic [SET_ADDR_LEN-1:0] idx_f, idx_e;
  logic [TAG_LEN-1:0]      tag_f, tag_e;
  logic                    unused_pc_lsbs;

  assign idx_f = PCF[SET_ADDR_LEN+1:2];
  assign tag_f = PCF[31:SET_ADDR_LEN+2];
  assign idx_e = PCE[SET_ADDR_LEN+1:2];
  assign tag_e = PCE[31:SET_ADDR_LEN+2];
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  // Fetch-side lookup: read-only, sees pre-edge contents
  logic             hit_f;
  logic [WAY_W-1:0] way_f;

  always_comb begin
    hit_f = 1'b0;
    way_f = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_f][w] && (tag_q[idx_f][w] == tag_f)) begin
        hit_f = 1'b1;
        way_f = WAY_W'(w);
      end
    end
  end

  assign HitF       = hit_f;
  assign PredTakenF = hit_f && cnt_q[idx_f][way_f][CNT_BITS-1];
  assign PredictPC  = PredTakenF ? tgt_q[idx_f][way_f] : PCF + 32'd4;

  // Training-side search and victim selection
  logic                hit_e, inv_found;
  logic [WAY_W-1:0]    hit_way_e, inv_way, lru_way, wr_way, old_age;
  logic                touch;
  logic [CNT_BITS-1:0] cnt_d;

  always_comb begin
    hit_e     = 1'b0;
    hit_way_e = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx_e][w] && (tag_q[idx_e][w] == tag_e)) begin
        hit_e     = 1'b1;
        hit_way_e = WAY_W'(w);
      end
      // Descending scan so the lowest-numbered invalid way wins
      if (!valid_q[idx_e][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[idx_e][w] == AGE_OLD) lru_way = WAY_W'(w);
    end
    wr_way  = hit_e ? hit_way_e : (inv_found ? inv_way : lru_way);
    old_age = age_q[idx_e][wr_way];
    touch   = UpdateE && (hit_e || BranchE);
    if (!hit_e)       cnt_d = CNT_WEAK;
    else if (BranchE) cnt_d = sat_inc(cnt_q[idx_e][wr_way]);
    else              cnt_d = sat_dec(cnt_q[idx_e][wr_way]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
          cnt_q[s][w]   <= '0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else if (Flush) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else if (touch) begin
      valid_q[idx_e][wr_way] <= 1'b1;
      tag_q[idx_e][wr_way]   <= tag_e;
      cnt_q[idx_e][wr_way]   <= cnt_d;
      if (BranchE) tgt_q[idx_e][wr_way] <= BrNPC;
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == wr_way)          age_q[idx_e][w] <= '0;
        else if (age_q[idx_e][w] < old_age) age_q[idx_e][w] <= age_q[idx_e][w] + WAY_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_assoc_branch_target_buffer.sv
// Directed bench for assoc_branch_target_buffer (default parameters: 8 sets, 2 ways, 2-bit counters).
// Expected lookup results are queued when stimulus is driven and popped when outputs are sampled.
module tb_assoc_branch_target_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCF = 32'h0;
  logic        HitF, PredTakenF;
  logic [31:0] PredictPC;
  logic        UpdateE = 1'b0;
  logic [31:0] PCE = 32'h0;
  logic        BranchE = 1'b0;
  logic [31:0] BrNPC = 32'h0;
  logic        Flush = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] pc;
    string       name;
  } exp_t;
  exp_t sb[$];

  assoc_branch_target_buffer dut (
    .clk(clk), .rst(rst), .PCF(PCF), .HitF(HitF), .PredTakenF(PredTakenF),
    .PredictPC(PredictPC), .UpdateE(UpdateE), .PCE(PCE), .BranchE(BranchE),
    .BrNPC(BrNPC), .Flush(Flush)
  );

  always #5 clk = ~clk;

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    tests++;
    assert (HitF === e.hit) else begin
      fails++;
      $error("FAIL %s HitF got %0b expected %0b", e.name, HitF, e.hit);
    end
    tests++;
    assert (PredTakenF === e.taken) else begin
      fails++;
      $error("FAIL %s PredTakenF got %0b expected %0b", e.name, PredTakenF, e.taken);
    end
    tests++;
    assert (PredictPC === e.pc) else begin
      fails++;
      $error("FAIL %s PredictPC got %h expected %h", e.name, PredictPC, e.pc);
    end
  endtask

  // Drive PCF now, sample 1 time unit later (called just after a falling edge)
  task automatic look_now(input logic [31:0] pc, input logic h, input logic t,
                          input logic [31:0] npc, input string name);
    exp_t e;
    e.hit = h; e.taken = t; e.pc = npc; e.name = name;
    PCF = pc;
    sb.push_back(e);
    #1;
    check_out();
  endtask

  task automatic look(input logic [31:0] pc, input logic h, input logic t,
                      input logic [31:0] npc, input string name);
    @(negedge clk);
    look_now(pc, h, t, npc, name);
  endtask

  task automatic upd(input logic [31:0] pce, input logic taken, input logic [31:0] npc);
    @(negedge clk);
    UpdateE = 1'b1; PCE = pce; BranchE = taken; BrNPC = npc;
    @(negedge clk);
    UpdateE = 1'b0; BranchE = 1'b0;
  endtask

  initial begin
    // Reset held, then released
    #2;
    look_now(32'h40, 1'b0, 1'b0, 32'h44, "reset_held");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    look_now(32'h40, 1'b0, 1'b0, 32'h44, "reset_released");

    // Allocation: lookup in the same cycle sees the old (empty) contents
    @(negedge clk);
    UpdateE = 1'b1; PCE = 32'h40; BranchE = 1'b1; BrNPC = 32'h100;
    look_now(32'h40, 1'b0, 1'b0, 32'h44, "alloc_same_cycle");
    @(negedge clk);
    UpdateE = 1'b0; BranchE = 1'b0;
    look_now(32'h40, 1'b1, 1'b1, 32'h100, "alloc_next_cycle");

    // Counter hysteresis: 2 -> 3 -> 2 -> 1
    upd(32'h40, 1'b1, 32'h100);
    look_now(32'h40, 1'b1, 1'b1, 32'h100, "cnt_sat_up");
    upd(32'h40, 1'b0, 32'h0);
    look_now(32'h40, 1'b1, 1'b1, 32'h100, "cnt_nt_once");
    upd(32'h40, 1'b0, 32'h0);
    look_now(32'h40, 1'b1, 1'b0, 32'h44, "cnt_nt_twice");

    // Target change on a hit: counter back to 2, target replaced
    upd(32'h40, 1'b1, 32'h200);
    look_now(32'h40, 1'b1, 1'b1, 32'h200, "target_change");

    // Not-taken miss allocates nothing
    upd(32'hA0, 1'b0, 32'h999);
    look_now(32'hA0, 1'b0, 1'b0, 32'hA4, "miss_nt_no_alloc");

    // Flush together with an update: old contents visible in the flush cycle, table empty after
    @(negedge clk);
    Flush = 1'b1; UpdateE = 1'b1; PCE = 32'h60; BranchE = 1'b1; BrNPC = 32'h600;
    look_now(32'h40, 1'b1, 1'b1, 32'h200, "flush_cycle_old");
    @(negedge clk);
    Flush = 1'b0; UpdateE = 1'b0; BranchE = 1'b0;
    look_now(32'h40, 1'b0, 1'b0, 32'h44, "flush_cleared");
    look(32'h60, 1'b0, 1'b0, 32'h64, "flush_beats_update");

    // LRU in set 0: 0x40 -> way0, 0x60 -> way1, touch 0x40, 0x80 must evict 0x60
    upd(32'h40, 1'b1, 32'h140);
    upd(32'h60, 1'b1, 32'h160);
    look_now(32'h60, 1'b1, 1'b1, 32'h160, "lru_second_way");
    upd(32'h40, 1'b1, 32'h140);
    upd(32'h80, 1'b1, 32'h180);
    look_now(32'h60, 1'b0, 1'b0, 32'h64, "lru_evicted");
    look(32'h40, 1'b1, 1'b1, 32'h140, "lru_kept");
    look(32'h80, 1'b1, 1'b1, 32'h180, "lru_new");

    // Other sets are independent
    upd(32'h44, 1'b1, 32'h300);
    look_now(32'h44, 1'b1, 1'b1, 32'h300, "set1_hit");
    look(32'h48, 1'b0, 1'b0, 32'h4C, "set2_miss");

    // PC+4 wraps at the top of the address space
    look(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, "pc_wrap");

    // Reset arriving mid-update: the update is lost and everything clears
    @(negedge clk);
    UpdateE = 1'b1; PCE = 32'h4C; BranchE = 1'b1; BrNPC = 32'h400;
    #2 rst = 1'b1;
    @(negedge clk);
    UpdateE = 1'b0; BranchE = 1'b0;
    look_now(32'h40, 1'b0, 1'b0, 32'h44, "reset_mid_held");
    rst = 1'b0;
    look(32'h4C, 1'b0, 1'b0, 32'h50, "reset_lost_update");
    look(32'h80, 1'b0, 1'b0, 32'h84, "reset_cleared");

    tests++;
    assert (sb.size() === 0) else begin
      fails++;
      $error("FAIL scoreboard_drain got %0d expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
